// File: rtl/rv_br_pkg.sv
// Shared definitions for branch resolution: funct3 codes, FSM states, datapath width.
package rv_br_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } br_state_e;

   // Only BLTU/BGEU compare unsigned.
   function automatic logic f3_is_unsigned(input logic [2:0] funct3);
      return funct3[2] & funct3[1];
   endfunction

endpackage

// File: rtl/br_resolve_if.sv
// Execute-stage to branch-resolution bundle: instruction/comparator inputs and redirect/flush/counter outputs.
interface br_resolve_if #(
   parameter int CNT_W = 16
);
   import rv_br_pkg::*;

   logic              valid_i;
   logic              is_br_i;
   logic              is_jmp_i;
   logic [2:0]        funct3_i;
   logic              br_less_i;
   logic              br_equal_i;
   logic              pred_taken_i;
   logic              stall_i;
   logic [XLEN-1:0]   pc_i;
   logic [XLEN-1:0]   target_i;
   logic              br_unsign_o;
   logic              redirect_o;
   logic [XLEN-1:0]   redirect_pc_o;
   logic              flush_o;
   logic              illegal_o;
   logic [CNT_W-1:0]  br_cnt_o;
   logic [CNT_W-1:0]  misp_cnt_o;

   modport master (
      output valid_i, is_br_i, is_jmp_i, funct3_i, br_less_i, br_equal_i,
             pred_taken_i, stall_i, pc_i, target_i,
      input  br_unsign_o, redirect_o, redirect_pc_o, flush_o, illegal_o,
             br_cnt_o, misp_cnt_o
   );

   modport slave (
      input  valid_i, is_br_i, is_jmp_i, funct3_i, br_less_i, br_equal_i,
             pred_taken_i, stall_i, pc_i, target_i,
      output br_unsign_o, redirect_o, redirect_pc_o, flush_o, illegal_o,
             br_cnt_o, misp_cnt_o
   );

endinterface

// File: rtl/br_decide.sv
// Combinational branch decision: funct3 + comparator flags -> taken / illegal / unsigned mode.
module br_decide
   import rv_br_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       is_jmp,
   input  logic       br_less,
   input  logic       br_equal,
   output logic       taken,
   output logic       illegal,
   output logic       unsign
);

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         BEQ:        taken = br_equal;
         BNE:        taken = ~br_equal;
         BLT, BLTU:  taken = br_less;
         BGE, BGEU:  taken = ~br_less;
         default:    illegal = 1'b1;
      endcase
      // Jumps ignore funct3 entirely, so a reserved code is not illegal for them.
      if (is_jmp) begin
         taken   = 1'b1;
         illegal = 1'b0;
      end
   end

   assign unsign = f3_is_unsigned(funct3);

endmodule

// File: rtl/br_resolve.sv
// Branch resolution: taken decision vs. prediction, redirect + fixed flush window, saturating perf counters.
// state | meaning
// IDLE  | resolving branches/jumps as they arrive
// FLUSH | flush_o high, wrong-path instructions ignored until window expires
module br_resolve
   import rv_br_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   br_resolve_if.slave    bus
);

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

   br_state_e        state, state_nxt;
   logic [3:0]       flush_cnt, flush_cnt_nxt;
   logic             taken, illegal_f3;
   logic             accept, mispredict;
   logic             redirect, illegal;
   logic [XLEN-1:0]  redirect_pc;
   logic [CNT_W-1:0] br_cnt, misp_cnt;

   br_decide u_decide (
      .funct3   (bus.funct3_i),
      .is_jmp   (bus.is_jmp_i),
      .br_less  (bus.br_less_i),
      .br_equal (bus.br_equal_i),
      .taken    (taken),
      .illegal  (illegal_f3),
      .unsign   (bus.br_unsign_o)
   );

   assign accept     = (state == IDLE) && bus.valid_i && !bus.stall_i
                       && (bus.is_br_i || bus.is_jmp_i);
   assign mispredict = accept && (taken != bus.pred_taken_i);

   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      case (state)
         IDLE: begin
            if (mispredict) begin
               state_nxt     = FLUSH;
               flush_cnt_nxt = FLUSH_INIT;
            end
         end
         FLUSH: begin
            if (flush_cnt == 4'd1) begin
               state_nxt     = IDLE;
               flush_cnt_nxt = 4'd0;
            end else begin
               flush_cnt_nxt = flush_cnt - 4'd1;
            end
         end
         default: begin
            state_nxt     = IDLE;
            flush_cnt_nxt = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= IDLE;
         flush_cnt <= 4'd0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         redirect    <= 1'b0;
         redirect_pc <= '0;
         illegal     <= 1'b0;
         br_cnt      <= '0;
         misp_cnt    <= '0;
      end else begin
         redirect <= mispredict;
         illegal  <= accept && illegal_f3;
         if (mispredict)
            redirect_pc <= taken ? bus.target_i : bus.pc_i + XLEN'(4);
         if (accept && (br_cnt != '1))
            br_cnt <= br_cnt + 1'b1;
         if (mispredict && (misp_cnt != '1))
            misp_cnt <= misp_cnt + 1'b1;
      end
   end

   assign bus.redirect_o    = redirect;
   assign bus.redirect_pc_o = redirect_pc;
   assign bus.illegal_o     = illegal;
   assign bus.flush_o       = (state == FLUSH);
   assign bus.br_cnt_o      = br_cnt;
   assign bus.misp_cnt_o    = misp_cnt;

endmodule

// File: tb/tb_br_resolve.sv
// Randomized + directed bench for br_resolve against a cycle-level behavioural model.
module tb_br_resolve;

   localparam int FC    = 2;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   br_resolve_if #(.CNT_W(CW)) bus ();

   br_resolve #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   // model state
   int          m_flush_left;
   int          m_br_cnt, m_misp_cnt;
   bit          m_redir, m_ill;
   logic [31:0] m_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else
         pass_cnt++;
   endtask

   function automatic bit model_taken(input logic [2:0] f3, input bit less, input bit eq, input bit jmp);
      if (jmp) return 1'b1;
      case (f3)
         3'd0:       return eq;
         3'd1:       return !eq;
         3'd4, 3'd6: return less;
         3'd5, 3'd7: return !less;
         default:    return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_flush_left = 0;
      m_br_cnt     = 0;
      m_misp_cnt   = 0;
      m_redir      = 1'b0;
      m_ill        = 1'b0;
      m_pc         = 32'd0;
   endtask

   task automatic compare_all();
      chk("redirect",    {31'd0, bus.redirect_o}, {31'd0, m_redir});
      chk("redirect_pc", bus.redirect_pc_o, m_pc);
      chk("flush",       {31'd0, bus.flush_o}, {31'd0, (m_flush_left > 0)});
      chk("illegal",     {31'd0, bus.illegal_o}, {31'd0, m_ill});
      chk("br_cnt",      32'(bus.br_cnt_o), 32'(m_br_cnt));
      chk("misp_cnt",    32'(bus.misp_cnt_o), 32'(m_misp_cnt));
   endtask

   // One cycle: drive at posedge+1, advance the model, compare at next posedge+1.
   task automatic step(input bit v, input bit br, input bit jmp, input logic [2:0] f3,
                       input bit less, input bit eq, input bit pred, input bit stall,
                       input logic [31:0] pc, input logic [31:0] tgt);
      bit acc, tk, misp;
      bus.valid_i      = v;
      bus.is_br_i      = br;
      bus.is_jmp_i     = jmp;
      bus.funct3_i     = f3;
      bus.br_less_i    = less;
      bus.br_equal_i   = eq;
      bus.pred_taken_i = pred;
      bus.stall_i      = stall;
      bus.pc_i         = pc;
      bus.target_i     = tgt;
      #1;
      chk("unsign", {31'd0, bus.br_unsign_o}, {31'd0, (f3 == 3'd6 || f3 == 3'd7)});
      acc  = (m_flush_left == 0) && v && !stall && (br || jmp);
      tk   = model_taken(f3, less, eq, jmp);
      misp = acc && (tk != pred);
      m_redir = misp;
      if (misp) m_pc = tk ? tgt : pc + 32'd4;
      m_ill = acc && !jmp && (f3 == 3'd2 || f3 == 3'd3);
      if (acc && m_br_cnt < CMAX) m_br_cnt++;
      if (misp && m_misp_cnt < CMAX) m_misp_cnt++;
      if (misp) m_flush_left = FC;
      else if (m_flush_left > 0) m_flush_left--;
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle();
      step(0, 0, 0, 3'd0, 0, 0, 0, 0, 32'd0, 32'd0);
   endtask

   task automatic rand_step();
      logic [31:0] pc;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 4) == 0), 3'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
           pc, $urandom & 32'hFFFF_FFFC);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.valid_i = 0; bus.is_br_i = 0; bus.is_jmp_i = 0; bus.funct3_i = 0;
      bus.br_less_i = 0; bus.br_equal_i = 0; bus.pred_taken_i = 0; bus.stall_i = 0;
      bus.pc_i = 0; bus.target_i = 0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_redirect", {31'd0, bus.redirect_o}, 32'd0);
      chk("rst_flush",    {31'd0, bus.flush_o}, 32'd0);
      chk("rst_br_cnt",   32'(bus.br_cnt_o), 32'd0);
      rst_n = 1'b1;

      // BLT signed, correctly predicted taken
      step(1, 1, 0, 3'b100, 1, 0, 1, 0, 32'h1000, 32'h2000);
      chk("blt_unsign",   {31'd0, bus.br_unsign_o}, 32'd0);
      chk("blt_redirect", {31'd0, bus.redirect_o}, 32'd0);
      chk("blt_flush",    {31'd0, bus.flush_o}, 32'd0);
      chk("blt_br_cnt",   32'(bus.br_cnt_o), 32'd1);

      // BGEU mispredicted not-taken, then a wrong-path mispredict inside the window
      step(1, 1, 0, 3'b111, 0, 0, 0, 0, 32'h1004, 32'h0000_0100);
      chk("bgeu_redirect", {31'd0, bus.redirect_o}, 32'd1);
      chk("bgeu_pc",       bus.redirect_pc_o, 32'h0000_0100);
      chk("bgeu_flush1",   {31'd0, bus.flush_o}, 32'd1);
      chk("bgeu_misp",     32'(bus.misp_cnt_o), 32'd1);
      step(1, 1, 0, 3'b000, 0, 0, 1, 0, 32'h2000, 32'h3000);
      chk("bgeu_flush2",   {31'd0, bus.flush_o}, 32'd1);
      chk("wrongpath_red", {31'd0, bus.redirect_o}, 32'd0);
      chk("wrongpath_cnt", 32'(bus.br_cnt_o), 32'd2);
      idle();
      chk("bgeu_flush3",   {31'd0, bus.flush_o}, 32'd0);

      // BEQ mispredicted taken, fall-through wraps
      step(1, 1, 0, 3'b000, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0000_1234);
      chk("beq_redirect", {31'd0, bus.redirect_o}, 32'd1);
      chk("beq_pc",       bus.redirect_pc_o, 32'h0000_0000);
      chk("beq_misp",     32'(bus.misp_cnt_o), 32'd2);
      idle();
      idle();

      // reserved funct3
      step(1, 1, 0, 3'b010, 0, 0, 0, 0, 32'h40, 32'h80);
      chk("ill_pulse",    {31'd0, bus.illegal_o}, 32'd1);
      chk("ill_redirect", {31'd0, bus.redirect_o}, 32'd0);
      chk("ill_br_cnt",   32'(bus.br_cnt_o), 32'd4);
      idle();
      chk("ill_drop",     {31'd0, bus.illegal_o}, 32'd0);

      // stalled mispredicting branch in IDLE
      step(1, 1, 0, 3'b000, 0, 0, 1, 1, 32'h50, 32'h90);
      chk("stall_br_cnt",   32'(bus.br_cnt_o), 32'd4);
      chk("stall_redirect", {31'd0, bus.redirect_o}, 32'd0);
      chk("stall_flush",    {31'd0, bus.flush_o}, 32'd0);

      // saturation: 20 mispredicting jumps (with both flags set, jump wins)
      for (int i = 0; i < 20; i++) begin
         step(1, 1, 1, 3'b010, 0, 0, 0, 0, 32'h100 + 32'(i * 4), 32'h8000);
         idle();
         idle();
      end
      chk("sat_br_cnt",   32'(bus.br_cnt_o), 32'hF);
      chk("sat_misp_cnt", 32'(bus.misp_cnt_o), 32'hF);

      for (int i = 0; i < 2000; i++)
         rand_step();

      // reset in the middle of a flush window
      while (m_flush_left != 0) idle();
      step(1, 0, 1, 3'b000, 0, 0, 0, 0, 32'h10, 32'h20);
      chk("pre_rst_flush", {31'd0, bus.flush_o}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_flush",    {31'd0, bus.flush_o}, 32'd0);
      chk("async_redirect", {31'd0, bus.redirect_o}, 32'd0);
      chk("async_pc",       bus.redirect_pc_o, 32'd0);
      chk("async_br_cnt",   32'(bus.br_cnt_o), 32'd0);
      chk("async_misp_cnt", 32'(bus.misp_cnt_o), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++)
         rand_step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
